// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one gcd_top core among NUM_REQ requesters,
// with a zero-operand bypass and a single job in flight.
module gcd_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic                     clockInput,
    input  logic                     resetInput,
    input  logic [NUM_REQ-1:0]       reqReadyInput,
    input  logic [NUM_REQ*WIDTH-1:0] reqADataInput,
    input  logic [NUM_REQ*WIDTH-1:0] reqBDataInput,
    output logic [NUM_REQ-1:0]       reqAckOutput,
    output logic [NUM_REQ-1:0]       respReadyOutput,
    output logic [WIDTH-1:0]         respDataOutput,
    input  logic [NUM_REQ-1:0]       respAckInput,
    output logic                     coreAReadyOutput,
    output logic [WIDTH-1:0]         coreADataOutput,
    input  logic                     coreAAckInput,
    output logic                     coreBReadyOutput,
    output logic [WIDTH-1:0]         coreBDataOutput,
    input  logic                     coreBAckInput,
    input  logic                     coreOReadyInput,
    input  logic [WIDTH-1:0]         coreODataInput,
    output logic                     coreOAckOutput,
    output logic [IDX_W-1:0]         grantIndexOutput,
    output logic                     busyOutput
);

    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [IDX_W-1:0]   grant_n;
    logic [WIDTH-1:0]   a_n, b_n, data_n;
    logic [NUM_REQ-1:0] req_ack_n, resp_ready_n, grant_oh;
    logic               core_a_ready_n, core_b_ready_n, core_o_ack_n, busy_n;
    logic               a_done, b_done;

    logic [WIDTH-1:0]   a_arr [NUM_REQ];
    logic [WIDTH-1:0]   b_arr [NUM_REQ];
    logic               found;
    logic [IDX_W-1:0]   win;
    logic [IDX_W:0]     sum;

    // Unpack the flat operand buses into per-requester arrays.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign a_arr[gi] = reqADataInput[gi*WIDTH +: WIDTH];
        assign b_arr[gi] = reqBDataInput[gi*WIDTH +: WIDTH];
    end

    assign grant_oh = NUM_REQ'(1) << grantIndexOutput;

    // Round-robin search: first pending requester starting at ptr.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            if (!found && reqReadyInput[sum[IDX_W-1:0]]) begin
                found = 1'b1;
                win   = sum[IDX_W-1:0];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n        = state;
        ptr_n          = ptr;
        grant_n        = grantIndexOutput;
        a_n            = coreADataOutput;
        b_n            = coreBDataOutput;
        data_n         = respDataOutput;
        req_ack_n      = '0;
        resp_ready_n   = respReadyOutput;
        core_a_ready_n = coreAReadyOutput;
        core_b_ready_n = coreBReadyOutput;
        core_o_ack_n   = 1'b0;
        a_done         = !coreAReadyOutput || coreAAckInput;
        b_done         = !coreBReadyOutput || coreBAckInput;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_n   = S_ACK;
                    grant_n   = win;
                    a_n       = a_arr[win];
                    b_n       = b_arr[win];
                    req_ack_n = NUM_REQ'(1) << win;
                end
            end
            S_ACK: begin
                if (coreADataOutput == '0 || coreBDataOutput == '0) begin
                    state_n      = S_RESPOND;
                    data_n       = coreADataOutput | coreBDataOutput;
                    resp_ready_n = grant_oh;
                end else begin
                    state_n        = S_ISSUE;
                    core_a_ready_n = 1'b1;
                    core_b_ready_n = 1'b1;
                end
            end
            S_ISSUE: begin
                core_a_ready_n = !a_done;
                core_b_ready_n = !b_done;
                if (a_done && b_done) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (coreOReadyInput) begin
                    state_n      = S_RESPOND;
                    data_n       = coreODataInput;
                    core_o_ack_n = 1'b1;
                    resp_ready_n = grant_oh;
                end
            end
            S_RESPOND: begin
                if (respAckInput[grantIndexOutput]) begin
                    state_n      = S_IDLE;
                    resp_ready_n = '0;
                    ptr_n        = (grantIndexOutput == LAST_IDX) ? '0
                                                                  : grantIndexOutput + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
        busy_n = (state_n != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clockInput) begin
        if (resetInput) begin
            state            <= S_IDLE;
            ptr              <= '0;
            grantIndexOutput <= '0;
            coreADataOutput  <= '0;
            coreBDataOutput  <= '0;
            respDataOutput   <= '0;
            reqAckOutput     <= '0;
            respReadyOutput  <= '0;
            coreAReadyOutput <= 1'b0;
            coreBReadyOutput <= 1'b0;
            coreOAckOutput   <= 1'b0;
            busyOutput       <= 1'b0;
        end else begin
            state            <= state_n;
            ptr              <= ptr_n;
            grantIndexOutput <= grant_n;
            coreADataOutput  <= a_n;
            coreBDataOutput  <= b_n;
            respDataOutput   <= data_n;
            reqAckOutput     <= req_ack_n;
            respReadyOutput  <= resp_ready_n;
            coreAReadyOutput <= core_a_ready_n;
            coreBReadyOutput <= core_b_ready_n;
            coreOAckOutput   <= core_o_ack_n;
            busyOutput       <= busy_n;
        end
    end

endmodule
